// File: rtl/ro_puf_scan_ctrl.sv
// Ring-oscillator PUF scan sequencer: walks a 16:1 oscillator mux,
// counts edges per oscillator and compares adjacent pairs.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - scan request, sampled only while idle
//   mux_out    - selected oscillator output, asynchronous to clk
//   sel        - oscillator mux select (equals the scan index)
//   busy       - high from start acceptance through the DONE cycle
//   resp_valid - one-cycle strobe, response complete
//   response   - 8-bit PUF response, one bit per oscillator pair
module ro_puf_scan_ctrl #(
    parameter int WINDOW = 256,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_out,
    output logic [3:0] sel,
    output logic       busy,
    output logic       resp_valid,
    output logic [7:0] response
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [7:0]       resp_q, resp_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_inc;

    // Two-flop synchronizer followed by an edge-detect stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= mux_out;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    // Saturating increment: a clamped count still orders correctly.
    always_comb begin
        cnt_inc = cnt_q;
        if (rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_inc = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            cnt_a_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            cnt_a_q <= cnt_a_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        cnt_a_d = cnt_a_q;
        resp_d  = resp_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    idx_d   = '0;
                    tmr_d   = '0;
                    resp_d  = '0;
                end
            end
            S_SETTLE: begin
                cnt_d = '0;
                if (tmr_q == SET_LAST) begin
                    tmr_d   = '0;
                    state_d = S_COUNT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_COUNT: begin
                cnt_d = cnt_inc;
                if (tmr_q == WIN_LAST) begin
                    tmr_d = '0;
                    if (!idx_q[0]) begin
                        // First of the pair: keep its count for the compare.
                        cnt_a_d = cnt_inc;
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_COMPARE;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_COMPARE: begin
                resp_d[idx_q[3:1]] = (cnt_a_q > cnt_q);
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel        = idx_q;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign response   = resp_q;

endmodule

// File: tb/tb_ro_puf_scan_ctrl.sv
// Directed bench for ro_puf_scan_ctrl: full scans, tie rule,
// saturation, start handling and mid-scan abort.
module tb_ro_puf_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start1, start2;
    logic       mux1, mux2;
    logic [3:0] sel1, sel2;
    logic       busy1, busy2;
    logic       rv1, rv2;
    logic [7:0] resp1, resp2;

    logic [1:0]  mode;
    int unsigned t;
    int          total;
    int          bad;

    ro_puf_scan_ctrl #(.WINDOW(16), .SETTLE(4), .CNT_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mux_out(mux1),
        .sel(sel1), .busy(busy1), .resp_valid(rv1), .response(resp1)
    );

    ro_puf_scan_ctrl #(.WINDOW(64), .SETTLE(4), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mux_out(mux2),
        .sel(sel2), .busy(busy2), .resp_valid(rv2), .response(resp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator model: fast = toggle every 2 clk, slow = every 4 clk.
    function automatic logic wave(input logic [3:0] s,
                                  input logic [1:0] m,
                                  input int unsigned tt);
        logic        fast;
        logic [31:0] tv;
        tv = tt;
        case (m)
            2'd0:    fast = ~s[0];
            2'd1:    fast = s[1] ? s[0] : ~s[0];
            2'd2:    fast = 1'b1;
            default: fast = s[0];
        endcase
        return fast ? tv[1] : tv[2];
    endfunction

    initial begin
        t    = 0;
        mux1 = 1'b0;
        mux2 = 1'b0;
    end

    always @(negedge clk) begin
        logic [31:0] tv;
        t    = t + 1;
        tv   = t;
        mux1 = wave(sel1, mode, t);
        mux2 = sel2[0] ? 1'b0 : tv[1];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One scan on the selected DUT; 'last' is the expected DONE cycle.
    task automatic scan(input bit which, input int last,
                        input logic [7:0] exp, input string nm,
                        input bit poke);
        int         nv, vc, bb;
        logic [7:0] r;
        logic       b, v;
        nv = 0; vc = -1; bb = 0; r = '0;
        @(posedge clk); #1;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        start2 = 1'b0;
        b = which ? busy2 : busy1;
        chk({nm, "_busy_c1"}, 32'(b), 32'd1);
        for (int c = 1; c <= last + 10; c++) begin
            if (c > 1) cyc();
            if (poke) start1 = (c == 50);
            b = which ? busy2 : busy1;
            v = which ? rv2 : rv1;
            if (v) begin
                nv++;
                vc = c;
                r  = which ? resp2 : resp1;
            end
            if (b !== (c <= last)) bb++;
        end
        chk({nm, "_nvalid"}, 32'(nv), 32'd1);
        chk({nm, "_vcycle"}, 32'(vc), 32'(last));
        chk({nm, "_resp"}, 32'(r), 32'(exp));
        chk({nm, "_busywin"}, 32'(bb), 32'd0);
        chk({nm, "_sel_end"}, 32'(which ? sel2 : sel1), 32'd15);
        chk({nm, "_resp_hold"}, 32'(which ? resp2 : resp1), 32'(exp));
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int         nb;
        int         vq[$];
        logic [7:0] rq[$];
        total  = 0;
        bad    = 0;
        mode   = 2'd0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;

        tbl[0] = '{2'd0, 8'hFF, "full"};
        tbl[1] = '{2'd1, 8'h55, "mixed"};
        tbl[2] = '{2'd2, 8'h00, "ties"};
        tbl[3] = '{2'd3, 8'h00, "reversed"};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        nb = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (sel1 !== 4'd0 || busy1 !== 1'b0 ||
                rv1 !== 1'b0 || resp1 !== 8'h00) nb++;
        end
        chk("reset_idle", 32'(nb), 32'd0);

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].m;
            scan(1'b0, 329, tbl[i].exp, tbl[i].nm, 1'b0);
        end

        scan(1'b1, 1097, 8'hFF, "saturate", 1'b0);

        mode = 2'd0;
        scan(1'b0, 329, 8'hFF, "poke_busy", 1'b1);

        // start held high: back-to-back scans
        mode = 2'd1;
        @(posedge clk); #1 start1 = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            cyc();
            if (rv1) begin
                vq.push_back(c);
                rq.push_back(resp1);
            end
        end
        start1 = 1'b0;
        nb = 0;
        while (busy1 && nb < 400) begin
            cyc();
            nb++;
        end
        chk("b2b_drain_timeout", 32'(busy1), 32'd0);
        chk("b2b_count", 32'(vq.size()), 32'd2);
        if (vq.size() == 2) begin
            chk("b2b_first", 32'(vq[0]), 32'd329);
            chk("b2b_space", 32'(vq[1] - vq[0]), 32'd330);
            chk("b2b_resp0", 32'(rq[0]), 32'h55);
            chk("b2b_resp1", 32'(rq[1]), 32'h55);
        end

        // Abort mid-COUNT at cycle 150
        mode = 2'd0;
        @(posedge clk); #1 start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        for (int c = 2; c <= 150; c++) cyc();
        chk("abort_pre_sel", 32'(sel1), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("abort_sel", 32'(sel1), 32'd0);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_rv", 32'(rv1), 32'd0);
        chk("abort_resp", 32'(resp1), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (rv1 || busy1) nb++;
        end
        chk("abort_quiet", 32'(nb), 32'd0);
        scan(1'b0, 329, 8'hFF, "after_abort", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ro_puf_scan_ctrl.md
# ro_puf_scan_ctrl

Sequencer for the ring-oscillator PUF array behind the 16:1 oscillator mux. On a start request it steps the mux select through all 16 oscillators and counts rising edges of the mux output over a fixed window. It then compares each adjacent oscillator pair and assembles an 8-bit PUF response, presented with a one-cycle valid strobe. It sits between the mux output and the response capture/readout logic, and is the only driver of the mux select lines.

## Interface
- WINDOW, 256: clock cycles per counting window (>=1)
- SETTLE, 4: clock cycles after each select change with counting disabled (>=1)
- CNT_W, 12: edge counter width; counters saturate at 2^CNT_W-1
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a scan; sampled only in IDLE
- mux_out  input  1  16:1 mux output, asynchronous to clk
- sel  output  4  mux select, drives the 16:1 mux
- busy  output  1  high from start acceptance until the end of DONE
- resp_valid  output  1  one-cycle strobe: response complete
- response  output  8  PUF response bits

## Operation
- One clock and one reset. Asynchronous, active-low reset rst_n. All state resets asynchronously.
- Reset values: sel=0, busy=0, resp_valid=0, response=0, FSM=IDLE, edge counter=0, stored count=0, index=0.
- mux_out passes through a 2-flop synchronizer and then an edge-detect register. The rise pulse is sync_q2 & ~sync_q3.
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
  - IDLE: when start=1, go to SETTLE, set index=0, sel=0, busy=1, response=0. Otherwise hold.
  - SETTLE: lasts SETTLE cycles. The edge counter is cleared on entry. Then go to COUNT.
  - COUNT: lasts WINDOW cycles. The counter increments on each cycle with a rise pulse and saturates at all-ones.
    - Even index: on exit, latch the count into cnt_a, set index+1 and sel=index+1, then go to SETTLE.
    - Odd index: on exit, go to COMPARE.
  - COMPARE: 1 cycle. response[index>>1] = (cnt_a > counter) ? 1 : 0. A tie gives 0.
    - If index=15, go to DONE.
    - Otherwise set index+1 and sel=index+1, then go to SETTLE.
  - DONE: 1 cycle with resp_valid=1. busy drops on leaving DONE. Then go to IDLE.
- sel always equals index. sel changes only on entry to SETTLE, and holds 15 after a scan until the next start.
- response holds its value after DONE until the next accepted start clears it. Consumers sample it only on resp_valid.
- start is ignored outside IDLE; it is not queued. start held high continuously re-triggers a scan in the cycle after DONE, when the FSM is back in IDLE.
- Reset asserted mid-scan aborts immediately to the reset values. No resp_valid is produced for the aborted scan.

## Timing
- Start accepted at cycle 0 (IDLE, start=1), so SETTLE begins at cycle 1.
- Per oscillator: SETTLE+WINDOW cycles. Per pair: one extra COMPARE cycle.
- resp_valid is high in cycle 16*(SETTLE+WINDOW)+8+1. With defaults this is cycle 4169. busy is high from cycle 1 through the same cycle.
- Edge pipeline latency is 3 clk cycles from a mux_out rise to the counted pulse. Pulses still in the pipeline when COUNT ends are not counted.
  - Edges arriving in the last SETTLE cycles of the previous window belong to the old oscillator. SETTLE>=3 prevents cross-counting. SETTLE values 1-2 are allowed, but cross-counting is then a known artefact.
- mux_out must toggle slower than clk/2 to be counted exactly. Faster inputs undercount; this is not an error.

## Test plan
Run all scenarios with WINDOW=16, SETTLE=4, CNT_W=5.
- Reset/idle: hold rst_n=0, then release with start=0 for 20 cycles → sel=0, busy=0, resp_valid=0, response=0 throughout.
- Full scan: the model toggles mux_out every 2 clk for even sel and every 4 clk for odd sel. Pulse start → busy in cycle 1, resp_valid single pulse in cycle 329, response=8'hFF.
- Mixed pattern: the even/odd rates are swapped for pairs 1, 3, 5 and 7 → response=8'h55.
  - Then force equal rates in all pairs and run another scan → response=8'h00 (tie rule).
- Saturation: WINDOW=64 and CNT_W=4, with toggling every 2 clk on even sel and mux_out=0 on odd sel. Even counts clamp at 15, no wrap → response=8'hFF.
- Start handling: pulse start at cycle 50 while busy → no effect, exactly one resp_valid.
  - Hold start high → back-to-back scans, each with one resp_valid, spaced 330 cycles apart.
- Abort: drop rst_n at cycle 150, mid-COUNT, for 3 cycles → all outputs at reset values immediately, no resp_valid. A new start then completes normally with the correct response.
